// File: rtl/memory_access_ctrl_pkg.sv
// Shared types for the memory-stage access controller.
// Holds the decoded memory-op arguments, the data-bus request/response
// structs and the controller state encoding, plus a misalignment helper.
package memory_access_ctrl_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } sign_t;

    typedef struct packed {
        logic   valid;  // instruction actually touches memory
        logic   write;  // store when set, load otherwise
        sign_t  sig;    // sign-extend loaded data
        msize_t msize;
    } memory_args_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } mem_ctrl_state_t;

    function automatic logic is_misaligned(input msize_t msize, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (msize)
            MSIZE2:  mis = offset[0];
            MSIZE4:  mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering for the data bus.
// Ports:
//   offset     - low two address bits of the access
//   msize, sig - access width and load extension mode
//   write      - store when set (strobe forced to 0 for loads)
//   wdata      - store source value; wdata_lane is it replicated across lanes
//   rdata_raw  - raw bus word; rdata is it shifted down and extended
//   strobe     - byte-enable for stores
module mem_align
    import memory_access_ctrl_pkg::*;
(
    input  logic [1:0]  offset,
    input  msize_t      msize,
    input  sign_t       sig,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  strobe,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic        sext;

    always_comb begin
        shifted    = rdata_raw >> {offset, 3'b000};
        sext       = 1'b0;
        strobe     = 4'b0000;
        wdata_lane = wdata;
        rdata      = shifted;
        case (msize)
            MSIZE1: begin
                strobe     = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                sext       = (sig == SIGNED) && shifted[7];
                rdata      = {{24{sext}}, shifted[7:0]};
            end
            MSIZE2: begin
                strobe     = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
                sext       = (sig == SIGNED) && shifted[15];
                rdata      = {{16{sext}}, shifted[15:0]};
            end
            default: begin
                strobe     = 4'b1111;
                wdata_lane = wdata;
                rdata      = shifted;
            end
        endcase
        if (!write) begin
            strobe = 4'b0000;
        end
    end

endmodule

// File: rtl/memory_access_ctrl.sv
// Memory-stage controller: accepts one instruction at a time, issues at most
// one data-bus request, waits for the response and hands the aligned result
// to writeback. Misaligned accesses raise exc_adel/exc_ades without touching
// the bus. A flush during a bus transaction lets the handshake finish but
// suppresses the result.
// Ports:
//   clk, reset            - clock, async active-high reset
//   in_valid/in_ready     - instruction handshake; in_args/in_addr/in_wdata payload
//   flush                 - kill the in-flight instruction
//   dreq/dresp            - data-bus request and response
//   out_valid/out_ready   - result handshake; out_rdata load result
//   exc_adel/exc_ades     - misaligned load/store, bad_vaddr the faulting address
module memory_access_ctrl
    import memory_access_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  memory_args_t in_args,
    input  logic [31:0]  in_addr,
    input  logic [31:0]  in_wdata,
    input  logic         flush,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_rdata,
    output logic         exc_adel,
    output logic         exc_ades,
    output logic [31:0]  bad_vaddr
);

    mem_ctrl_state_t state_q, state_d;
    memory_args_t    args_q, args_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            killed_q, killed_d;
    logic            adel_q, adel_d;
    logic            ades_q, ades_d;
    logic [31:0]     bad_vaddr_q, bad_vaddr_d;

    logic            accept;
    logic            mis_in;
    logic            is_load_q;
    logic [3:0]      strobe_al;
    logic [31:0]     wdata_al;
    logic [31:0]     rdata_al;

    assign accept = in_valid && in_ready;
    assign mis_in = in_args.valid && is_misaligned(in_args.msize, in_addr[1:0]);

    always_comb begin
        state_d     = state_q;
        args_d      = args_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        killed_d    = killed_q;
        adel_d      = adel_q;
        ades_d      = ades_q;
        bad_vaddr_d = bad_vaddr_q;
        unique case (state_q)
            IDLE: begin
                // A flush in IDLE drops whatever is being offered this cycle.
                if (!flush && accept) begin
                    args_d      = in_args;
                    addr_d      = in_addr;
                    wdata_d     = in_wdata;
                    killed_d    = 1'b0;
                    adel_d      = mis_in && !in_args.write;
                    ades_d      = mis_in && in_args.write;
                    bad_vaddr_d = mis_in ? in_addr : 32'd0;
                    state_d     = (in_args.valid && !mis_in) ? REQ : DONE;
                end
            end
            REQ: begin
                if (flush) begin
                    killed_d = 1'b1;
                end
                if (dresp.addr_ok) begin
                    if (dresp.data_ok) begin
                        rdata_d = dresp.data;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    killed_d = 1'b1;
                end
                if (dresp.data_ok) begin
                    rdata_d = dresp.data;
                    state_d = DONE;
                end
            end
            DONE: begin
                // A killed result is dropped without waiting for writeback.
                if (flush || killed_q || out_ready) begin
                    state_d     = IDLE;
                    killed_d    = 1'b0;
                    adel_d      = 1'b0;
                    ades_d      = 1'b0;
                    bad_vaddr_d = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            args_q      <= '0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            killed_q    <= 1'b0;
            adel_q      <= 1'b0;
            ades_q      <= 1'b0;
            bad_vaddr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            args_q      <= args_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            killed_q    <= killed_d;
            adel_q      <= adel_d;
            ades_q      <= ades_d;
            bad_vaddr_q <= bad_vaddr_d;
        end
    end

    mem_align u_mem_align (
        .offset     (addr_q[1:0]),
        .msize      (args_q.msize),
        .sig        (args_q.sig),
        .write      (args_q.write),
        .wdata      (wdata_q),
        .rdata_raw  (rdata_q),
        .strobe     (strobe_al),
        .wdata_lane (wdata_al),
        .rdata      (rdata_al)
    );

    assign is_load_q = args_q.valid && !args_q.write && !adel_q;

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE) && !killed_q;
    assign out_rdata   = ((state_q == DONE) && is_load_q) ? rdata_al : 32'd0;
    assign exc_adel    = adel_q;
    assign exc_ades    = ades_q;
    assign bad_vaddr   = bad_vaddr_q;

    assign dreq.valid  = (state_q == REQ);
    assign dreq.addr   = addr_q;
    assign dreq.size   = args_q.msize;
    assign dreq.strobe = strobe_al;
    assign dreq.data   = wdata_al;

endmodule

// File: doc/memory_access_ctrl.md
MEMORY_ACCESS_CTRL -- requirements
Module: memory_access_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  memory-stage instruction present.
REQ-004 SHALL have port in_ready  output  1  block can accept an instruction.
REQ-005 SHALL have port in_args  input  memory_args_t  decoded valid/write/sig/msize.
REQ-006 SHALL have port in_addr  input  32  effective virtual address.
REQ-007 SHALL have port in_wdata  input  32  store source register value.
REQ-008 SHALL have port flush  input  1  kill in-flight instruction (exception/eret).
REQ-009 SHALL have port dreq  output  dbus_req_t  valid, addr, size, strobe, data.
REQ-010 SHALL have port dresp  input  dbus_resp_t  addr_ok, data_ok, data.
REQ-011 SHALL have port out_valid  output  1  result ready for writeback.
REQ-012 SHALL have port out_ready  input  1  writeback consumes result.
REQ-013 SHALL have port out_rdata  output  32  aligned, extended load data (0 for stores/non-memory).
REQ-014 SHALL have ports exc_adel, exc_ades  output  1 each, and bad_vaddr  output  32: misaligned load/store report.

Function
REQ-015 SHALL implement states IDLE, REQ, WAIT, DONE; in_ready = (state==IDLE).
REQ-016 SHALL, on in_valid&in_ready, register args/addr/wdata; next state: REQ if args.valid and aligned; DONE otherwise (non-memory op or misaligned).
REQ-017 SHALL define misaligned as MSIZE2 with addr[0]=1, or MSIZE4 with addr[1:0]!=0; set exc_adel (load) or exc_ades (store), bad_vaddr=addr; issue no bus request.
REQ-018 SHALL drive dreq.valid=1 only in REQ, holding addr/size/strobe/data stable until addr_ok.
REQ-019 SHALL, in REQ: addr_ok&data_ok -> DONE; addr_ok only -> WAIT; neither -> stay.
REQ-020 SHALL, in WAIT, go to DONE on data_ok, latching dresp.data.
REQ-021 SHALL drive store strobe: MSIZE1 4'b0001<<addr[1:0]; MSIZE2 4'b0011<<addr[1:0]; MSIZE4 4'b1111; loads strobe 0.
REQ-022 SHALL replicate store data: MSIZE1 {4{wdata[7:0]}}; MSIZE2 {2{wdata[15:0]}}; MSIZE4 wdata.
REQ-023 SHALL form load data as dresp.data>>(8*addr[1:0]), truncated to msize, sign-extended when sig=SIGNED else zero-extended.
REQ-024 SHALL assert out_valid in DONE unless killed; DONE->IDLE when out_ready.
REQ-025 SHALL, on flush in IDLE or DONE, return to IDLE next cycle with out_valid=0 and exception flags cleared.
REQ-026 SHALL, on flush in REQ/WAIT, set a killed flag, still complete the bus handshake (no abandoned request), then go IDLE from DONE without out_valid.
REQ-027 SHALL give minimum latency accept->out_valid of 2 cycles for bus ops (addr_ok&data_ok in first REQ cycle), 1 cycle for non-memory/misaligned.

Reset
REQ-028 SHALL, on reset asserted (any state, mid-transaction included), immediately enter IDLE with dreq.valid=0, out_valid=0, out_rdata=0, exc flags=0, bad_vaddr=0, killed=0.

Structure
REQ-029 SHALL place state enum mem_ctrl_state_t in the shared mycpu package beside memory_args_t; dbus_req_t/dbus_resp_t stay in common.
REQ-030 SHALL factor lane steering/extension (REQ-021..023) into combinational sub-module mem_align.

Verification
REQ-031 SW addr 0x1000, wdata 0xDEADBEEF, addr_ok&data_ok same cycle -> dreq strobe 4'b1111, data 0xDEADBEEF; out_valid 2 cycles after accept.
REQ-032 LB addr 0x1003, dresp.data 0x80FF_FFFF after 3 wait cycles -> out_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr 0x2002, wdata 0x1234 -> strobe 4'b1100, data 0x12341234; LH addr 0x2001 -> exc_adel=1, bad_vaddr 0x2001, no dreq.valid.
REQ-034 LW, flush during WAIT, data_ok 2 cycles later -> no out_valid, IDLE after data_ok, next instruction accepted.
REQ-035 reset asserted while REQ with addr_ok low -> dreq.valid 0 same cycle, in_ready 1 after release.
REQ-036 out_ready held low 5 cycles in DONE -> out_valid/out_rdata stable, in_ready 0 throughout.
